cheriot_dbus_initiator: RTL

- Synthesizable initiator (requester) for the CHERIoT data bus: req/gnt/rvalid, 33-bit tagged data, is_cap, err.
- The opposite end of the data-memory responder. Drives bus traffic from a simple command port.
- Used as a standalone traffic source in block-level benches and by future DMA/scrubber agents that need core-equivalent bus behaviour.
- Capability accesses are split into two in-order word beats (addr, addr+4), matching the core's LSU.

---
 rtl/cheriot_dbus_initiator.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cheriot_dbus_initiator.sv
// cheriot_dbus_initiator: requester for the CHERIoT data bus.
// Turns single commands into word beats on the req/gnt/rvalid bus. A
// capability command becomes two in-order beats (addr, addr+4) and gets one
// assembled response. Responses are tracked in a small in-order FIFO.
// Optional build macro CHERIOT_DBUS_TIMEOUT_EN adds timeout_o, a sticky
// gnt-wait watchdog.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no command in flight on the request side; may accept one
// REQ0     | first (or only) beat requested, waiting for gnt
// REQ1     | second cap beat; req may be low until a tracking slot frees
// ERR_RSP  | misaligned cap command, error response issued next cycle
module cheriot_dbus_initiator #(
  parameter int unsigned DataWidth      = 33,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [3:0]               cmd_be_i,
  input  logic                     cmd_is_cap_i,
  input  logic [31:0]              cmd_addr_i,
  input  logic [2*DataWidth-1:0]   cmd_wdata_i,
  output logic                     data_req_o,
  input  logic                     data_gnt_i,
  input  logic                     data_rvalid_i,
  output logic                     data_we_o,
  output logic [3:0]               data_be_o,
  output logic                     data_is_cap_o,
  output logic [31:0]              data_addr_o,
  output logic [DataWidth-1:0]     data_wdata_o,
  input  logic [DataWidth-1:0]     data_rdata_i,
  input  logic                     data_err_i,
  output logic                     rsp_valid_o,
  output logic [2*DataWidth-1:0]   rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     rsp_is_cap_o,
  output logic [3:0]               outstanding_o,
`ifdef CHERIOT_DBUS_TIMEOUT_EN
  output logic                     timeout_o,
`endif
  output logic                     proto_err_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq0   = 2'd1;
  localparam logic [1:0] StReq1   = 2'd2;
  localparam logic [1:0] StErrRsp = 2'd3;

  localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [3:0]  MaxOut = 4'(MaxOutstanding);

  logic [1:0]             state_q;
  logic                   run_q;
  logic                   data_req_q;
  logic                   data_we_q;
  logic [3:0]             data_be_q;
  logic                   data_is_cap_q;
  logic [31:0]            data_addr_q;
  logic [DataWidth-1:0]   data_wdata_q;
  logic [DataWidth-1:0]   wdata_hi_q;

  logic [3:0]             cnt_q;
  logic [3:0]             cnt_d;
  logic [1:0]             fifo_q [MaxOutstanding];
  logic [PtrW-1:0]        wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic                   proto_err_q;

  logic                   rsp_valid_q;
  logic [2*DataWidth-1:0] rsp_rdata_q;
  logic                   rsp_err_q;
  logic                   rsp_is_cap_q;
  logic [DataWidth-1:0]   asm_lo_q;
  logic                   asm_err_q;

  logic                   cmd_misaligned_cap;
  logic                   cmd_accept;
  logic                   grant;
  logic                   pop;
  logic                   stray;
  logic                   head_is_cap;
  logic                   head_beat;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // A misaligned cap produces only an error response, so it waits for an
  // empty tracker to keep that response from overtaking earlier ones.
  assign cmd_misaligned_cap = cmd_is_cap_i && (cmd_addr_i[2:0] != 3'b000);
  assign cmd_ready_o = run_q && (state_q == StIdle) && (cnt_q < MaxOut) &&
                       (!cmd_misaligned_cap || (cnt_q == 4'd0));
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;

  assign grant = data_req_q && data_gnt_i;
  assign pop   = data_rvalid_i && (cnt_q != 4'd0);
  assign stray = data_rvalid_i && (cnt_q == 4'd0);

  assign head_is_cap = fifo_q[rd_ptr_q][1];
  assign head_beat   = fifo_q[rd_ptr_q][0];

  // Outstanding count after this cycle's grant/response.
  always_comb begin
    cnt_d = cnt_q;
    if (grant && !pop) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!grant && pop) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Keeps cmd_ready_o low while in reset and for the first cycle after it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Request-side FSM and registered bus outputs; fields only change on
  // accept or on moving to beat1, so they hold while gnt is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      data_req_q    <= 1'b0;
      data_we_q     <= 1'b0;
      data_be_q     <= 4'h0;
      data_is_cap_q <= 1'b0;
      data_addr_q   <= 32'h0;
      data_wdata_q  <= '0;
      wdata_hi_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_accept) begin
            if (cmd_misaligned_cap) begin
              state_q <= StErrRsp;
            end else begin
              state_q       <= StReq0;
              data_req_q    <= 1'b1;
              data_we_q     <= cmd_we_i;
              data_be_q     <= cmd_is_cap_i ? 4'hF : cmd_be_i;
              data_is_cap_q <= cmd_is_cap_i;
              data_addr_q   <= {cmd_addr_i[31:2], 2'b00};
              data_wdata_q  <= cmd_wdata_i[DataWidth-1:0];
              wdata_hi_q    <= cmd_wdata_i[2*DataWidth-1:DataWidth];
            end
          end
        end
        StReq0: begin
          if (grant) begin
            if (data_is_cap_q) begin
              state_q      <= StReq1;
              data_req_q   <= (cnt_d < MaxOut);
              data_addr_q  <= data_addr_q + 32'd4;
              data_wdata_q <= wdata_hi_q;
            end else begin
              state_q    <= StIdle;
              data_req_q <= 1'b0;
            end
          end
        end
        StReq1: begin
          if (grant) begin
            state_q    <= StIdle;
            data_req_q <= 1'b0;
          end else if (!data_req_q) begin
            data_req_q <= (cnt_d < MaxOut);
          end
        end
        StErrRsp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          data_req_q <= 1'b0;
        end
      endcase
    end
  end

  // In-order beat tracker: push {is_cap, beat} on grant, pop on rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        fifo_q[i] <= 2'b00;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= 4'd0;
      proto_err_q <= 1'b0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr_q] <= {data_is_cap_q, (state_q == StReq1)};
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_d;
      if (stray) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Response assembly: word and cap-beat1 responses leave one cycle after
  // rvalid; cap beat0 is parked in the assembly register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_is_cap_q <= 1'b0;
      asm_lo_q     <= '0;
      asm_err_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == StErrRsp) begin
        rsp_valid_q  <= 1'b1;
        rsp_rdata_q  <= '0;
        rsp_err_q    <= 1'b1;
        rsp_is_cap_q <= 1'b1;
      end else if (pop) begin
        if (!head_is_cap) begin
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= {{DataWidth{1'b0}}, data_rdata_i};
          rsp_err_q    <= data_err_i;
          rsp_is_cap_q <= 1'b0;
        end else if (!head_beat) begin
          asm_lo_q  <= data_rdata_i;
          asm_err_q <= data_err_i;
        end else begin
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= {data_rdata_i, asm_lo_q};
          rsp_err_q    <= asm_err_q | data_err_i;
          rsp_is_cap_q <= 1'b1;
        end
      end
    end
  end

`ifdef CHERIOT_DBUS_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TimeoutCycles + 1);

  logic [TmrW-1:0] tmr_q;
  logic            timeout_q;

  // Down-counter armed with TimeoutCycles; reaching terminal count while
  // still waiting for gnt raises the sticky flag. The request stays up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_q     <= TmrW'(TimeoutCycles);
      timeout_q <= 1'b0;
    end else if (data_req_q && !data_gnt_i) begin
      if (tmr_q != '0) begin
        tmr_q <= tmr_q - TmrW'(1);
      end
      if (tmr_q == TmrW'(1)) begin
        timeout_q <= 1'b1;
      end
    end else begin
      tmr_q <= TmrW'(TimeoutCycles);
    end
  end

  assign timeout_o = timeout_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TimeoutCycles);
`endif

  assign data_req_o    = data_req_q;
  assign data_we_o     = data_we_q;
  assign data_be_o     = data_be_q;
  assign data_is_cap_o = data_is_cap_q;
  assign data_addr_o   = data_addr_q;
  assign data_wdata_o  = data_wdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_is_cap_o  = rsp_is_cap_q;
  assign outstanding_o = cnt_q;
  assign proto_err_o   = proto_err_q;

endmodule
